// File: rtl/dram_io_pkg.sv
// Shared defaults and FSM state encoding for the DRAM PISO readout path.
// Latency: n/a (types only).  Backpressure: n/a.
package dram_io_pkg;

    localparam int NLANES_DEF = 16;
    localparam int NBITS_DEF  = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        RD_DONE  = 3'd4
    } rd_state_t;

endpackage

// File: rtl/piso_clk_gen.sv
// Drives the PISO shift clock and load strobe, and flags capture / last-bit points.
// Latency: pins registered from the reader's next state, so they line up with its state.
// Backpressure: none.
module piso_clk_gen #(
    parameter int DIV   = 2,
    parameter int NBITS = 8,
    parameter int BW    = 4
) (
    input  logic          clk_100m,
    input  logic          rst_n,
    input  logic          load_nxt,
    input  logic          hi_nxt,
    input  logic          lo_now,
    input  logic          hi_now,
    input  logic [3:0]    phase_q,
    input  logic [BW-1:0] bit_q,
    output logic          pc_clk,
    output logic          pc_clk_inv,
    output logic          pc_sr_ld_n,
    output logic          phase_last,
    output logic          capture,
    output logic          last_bit
);

    localparam logic [3:0]    PH_LAST  = 4'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);

    logic pc_clk_d, pc_clk_q;
    logic pc_clk_inv_d, pc_clk_inv_q;
    logic pc_sr_ld_n_d, pc_sr_ld_n_q;

    always_comb begin
        pc_clk_d     = hi_nxt;
        pc_clk_inv_d = ~hi_nxt;
        pc_sr_ld_n_d = ~load_nxt;
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            pc_clk_q     <= 1'b0;
            pc_clk_inv_q <= 1'b1;
            pc_sr_ld_n_q <= 1'b1;
        end else begin
            pc_clk_q     <= pc_clk_d;
            pc_clk_inv_q <= pc_clk_inv_d;
            pc_sr_ld_n_q <= pc_sr_ld_n_d;
        end
    end

    // Sample lanes on the last low cycle, just before pc_clk rises and the PISO shifts.
    assign phase_last = (phase_q == PH_LAST);
    assign capture    = lo_now & phase_last;
    assign last_bit   = hi_now & (bit_q == BIT_LAST);

    assign pc_clk     = pc_clk_q;
    assign pc_clk_inv = pc_clk_inv_q;
    assign pc_sr_ld_n = pc_sr_ld_n_q;

endmodule

// File: rtl/dram_piso_reader.sv
// Loads external PISO registers, shifts NBITS bits per lane MSB first, publishes the word.
// Latency: LOAD_CYC + 2*DIV*NBITS + 1 cycles from start accept to done.
// Backpressure: start is taken only in IDLE; abort drops the readout at once.
module dram_piso_reader
    import dram_io_pkg::*;
#(
    parameter int NLANES   = NLANES_DEF,
    parameter int NBITS    = NBITS_DEF,
    parameter int DIV      = 2,
    parameter int LOAD_CYC = 2
) (
    input  logic                      clk_100m,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [NLANES-1:0]         DRAM16_data,
    output logic                      pc_clk,
    output logic                      pc_sr_ld_n,
    output logic                      pc_clk_inv,
    output logic                      busy,
    output logic                      done,
    output logic                      data_valid,
    output logic [NLANES*NBITS-1:0]   data_out
);

    localparam int         BW        = $clog2(NBITS + 1);
    localparam logic [3:0] LOAD_LAST = 4'(LOAD_CYC - 1);

    rd_state_t                 state_q, state_d;
    logic [3:0]                phase_q, phase_d;
    logic [BW-1:0]             bit_q, bit_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      data_valid_q, data_valid_d;
    logic [NLANES*NBITS-1:0]   data_out_q, data_out_d;
    logic [NLANES*NBITS-1:0]   cap_word;
    logic                      capture, last_bit, phase_last;

    piso_clk_gen #(
        .DIV   (DIV),
        .NBITS (NBITS),
        .BW    (BW)
    ) u_clk_gen (
        .clk_100m   (clk_100m),
        .rst_n      (rst_n),
        .load_nxt   (state_d == LOAD),
        .hi_nxt     (state_d == SHIFT_HI),
        .lo_now     (state_q == SHIFT_LO),
        .hi_now     (state_q == SHIFT_HI),
        .phase_q    (phase_q),
        .bit_q      (bit_q),
        .pc_clk     (pc_clk),
        .pc_clk_inv (pc_clk_inv),
        .pc_sr_ld_n (pc_sr_ld_n),
        .phase_last (phase_last),
        .capture    (capture),
        .last_bit   (last_bit)
    );

    // Each lane shifts left, so the first captured bit ends up in the MSB.
    for (genvar l = 0; l < NLANES; l++) begin : g_lane
        logic [NBITS-1:0] sh_d, sh_q;

        always_comb begin
            sh_d = sh_q;
            if (capture) begin
                sh_d = {sh_q[NBITS-2:0], DRAM16_data[l]};
            end
        end

        always_ff @(posedge clk_100m or negedge rst_n) begin
            if (!rst_n) begin
                sh_q <= '0;
            end else begin
                sh_q <= sh_d;
            end
        end

        assign cap_word[NBITS*l +: NBITS] = sh_q;
    end

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        bit_d        = bit_q;
        data_valid_d = data_valid_q;
        data_out_d   = data_out_q;
        if (abort) begin
            state_d = IDLE;
            phase_d = 4'd0;
            bit_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d      = LOAD;
                        phase_d      = 4'd0;
                        bit_d        = '0;
                        data_valid_d = 1'b0;
                    end
                end
                LOAD: begin
                    if (phase_q == LOAD_LAST) begin
                        state_d = SHIFT_LO;
                        phase_d = 4'd0;
                    end else begin
                        phase_d = phase_q + 4'd1;
                    end
                end
                SHIFT_LO: begin
                    if (phase_last) begin
                        state_d = SHIFT_HI;
                        phase_d = 4'd0;
                    end else begin
                        phase_d = phase_q + 4'd1;
                    end
                end
                SHIFT_HI: begin
                    if (phase_last) begin
                        phase_d = 4'd0;
                        if (last_bit) begin
                            state_d = RD_DONE;
                            bit_d   = '0;
                        end else begin
                            state_d = SHIFT_LO;
                            bit_d   = bit_q + BW'(1);
                        end
                    end else begin
                        phase_d = phase_q + 4'd1;
                    end
                end
                RD_DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        done_d = (state_d == RD_DONE);
        busy_d = (state_d != IDLE);
        if (state_d == RD_DONE) begin
            data_out_d   = cap_word;
            data_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            phase_q      <= 4'd0;
            bit_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            data_valid_q <= 1'b0;
            data_out_q   <= '0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            bit_q        <= bit_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            data_valid_q <= data_valid_d;
            data_out_q   <= data_out_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign data_valid = data_valid_q;
    assign data_out   = data_out_q;

endmodule

// File: tb/tb_dram_piso_reader.sv
// Bench for dram_piso_reader: behavioural PISO lanes plus a scoreboard of expected
// completion cycles and words, checked as each done pulse arrives.
module tb_dram_piso_reader;

    localparam int NL = 16;
    localparam int NB = 8;
    localparam int W  = NL * NB;

    logic          clk_100m = 1'b0;
    logic          rst_n    = 1'b0;
    logic          start    = 1'b0;
    logic          abort    = 1'b0;
    logic [NL-1:0] dram_dat;
    logic          pc_clk, pc_sr_ld_n, pc_clk_inv, busy, done, data_valid;
    logic [W-1:0]  data_out;

    dram_piso_reader #(
        .NLANES   (NL),
        .NBITS    (NB),
        .DIV      (2),
        .LOAD_CYC (2)
    ) dut (
        .clk_100m    (clk_100m),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .DRAM16_data (dram_dat),
        .pc_clk      (pc_clk),
        .pc_sr_ld_n  (pc_sr_ld_n),
        .pc_clk_inv  (pc_clk_inv),
        .busy        (busy),
        .done        (done),
        .data_valid  (data_valid),
        .data_out    (data_out)
    );

    always #5 clk_100m = ~clk_100m;

    typedef struct {
        int unsigned  at;
        logic [W-1:0] dat;
    } exp_t;

    exp_t         sb[$];
    int unsigned  cyc = 0;
    int           errors = 0;
    int           checks = 0;
    int           inv_bad = 0;
    int           rises = 0;
    logic         pc_clk_prev = 1'b0;
    logic [7:0]   piso [NL];
    logic [7:0]   lane_load [NL];
    logic [W-1:0] last_dat = '0;
    int unsigned  c0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // External PISO model: parallel load while SR/LD# low, shift on pc_clk rise.
    always @(posedge clk_100m) begin
        cyc <= cyc + 1;
        for (int i = 0; i < NL; i++) begin
            if (!pc_sr_ld_n) piso[i] <= lane_load[i];
            else if (pc_clk && !pc_clk_prev) piso[i] <= {piso[i][6:0], 1'b0};
        end
        if (!busy) rises <= 0;
        else if (pc_clk && !pc_clk_prev) rises <= rises + 1;
        pc_clk_prev <= pc_clk;
    end

    always_comb begin
        for (int i = 0; i < NL; i++) dram_dat[i] = piso[i][7];
    end

    always @(negedge clk_100m) begin
        exp_t e;
        if (pc_clk_inv !== ~pc_clk) inv_bad++;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", W'(1), W'(0));
            end else begin
                e = sb.pop_front();
                chk("done_cyc", W'(cyc), W'(e.at));
                chk("data_out", data_out, e.dat);
                chk("data_valid", W'(data_valid), W'(1));
                chk("pc_clk_rises", W'(rises), W'(8));
                last_dat = e.dat;
            end
        end
    end

    function automatic logic [W-1:0] pack_exp();
        logic [W-1:0] r;
        for (int i = 0; i < NL; i++) r[8*i +: 8] = lane_load[i];
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk_100m);
    endtask

    task automatic at_cyc(input int unsigned t);
        while (cyc < t) tick(1);
    endtask

    task automatic load_random();
        for (int i = 0; i < NL; i++) lane_load[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic pulse_start();
        exp_t e;
        e.at  = cyc + 35;
        e.dat = pack_exp();
        sb.push_back(e);
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while (sb.size() != 0 && n < maxc) begin
            tick(1);
            n++;
        end
        chk("drain", W'(sb.size()), W'(0));
        tick(2);
    endtask

    task automatic chk_idle_pins(input string tag);
        chk({tag, "_busy"}, W'(busy), W'(0));
        chk({tag, "_pc_clk"}, W'(pc_clk), W'(0));
        chk({tag, "_pc_clk_inv"}, W'(pc_clk_inv), W'(1));
        chk({tag, "_pc_sr_ld_n"}, W'(pc_sr_ld_n), W'(1));
        chk({tag, "_done"}, W'(done), W'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NL; i++) lane_load[i] = 8'h00;
        tick(3);
        chk_idle_pins("rst");
        chk("rst_data_valid", W'(data_valid), W'(0));
        chk("rst_data_out", data_out, W'(0));
        rst_n = 1'b1;
        tick(2);

        // all lanes 0x55
        for (int i = 0; i < NL; i++) lane_load[i] = 8'h55;
        pulse_start();
        chk("busy_running", W'(busy), W'(1));
        chk("dv_cleared", W'(data_valid), W'(0));
        drain(60);

        // lane 1 = A5, lane 16 = 3C, rest zero
        for (int i = 0; i < NL; i++) lane_load[i] = 8'h00;
        lane_load[0]  = 8'hA5;
        lane_load[15] = 8'h3C;
        pulse_start();
        drain(60);
        chk("lane1_byte", W'(data_out[7:0]), W'(8'hA5));
        chk("lane16_byte", W'(data_out[127:120]), W'(8'h3C));
        chk("middle_bytes", W'(data_out[119:8]), W'(0));

        for (int k = 0; k < 2; k++) begin
            load_random();
            pulse_start();
            drain(60);
        end

        // second start mid-readout must be ignored
        load_random();
        c0 = cyc;
        pulse_start();
        at_cyc(c0 + 10);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        drain(60);
        tick(40);

        // abort during shifting keeps the previous word
        load_random();
        c0 = cyc;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        at_cyc(c0 + 12);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk_idle_pins("abort");
        chk("abort_data_valid", W'(data_valid), W'(0));
        chk("abort_data_out", data_out, last_dat);
        tick(40);
        chk("abort_no_done_dv", W'(data_valid), W'(0));

        // abort beats start in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick(1);
        start = 1'b0;
        abort = 1'b0;
        chk("abort_wins_busy", W'(busy), W'(0));
        tick(1);
        chk("abort_wins_busy2", W'(busy), W'(0));

        // reset mid-readout, then a clean readout
        load_random();
        c0 = cyc;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        at_cyc(c0 + 20);
        rst_n = 1'b0;
        #1;
        chk_idle_pins("midrst");
        chk("midrst_data_valid", W'(data_valid), W'(0));
        chk("midrst_data_out", data_out, W'(0));
        last_dat = '0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        load_random();
        pulse_start();
        drain(60);

        // start held high: back-to-back readouts one IDLE cycle apart
        load_random();
        c0 = cyc;
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            e.at  = c0 + 35 + 36 * k;
            e.dat = pack_exp();
            sb.push_back(e);
        end
        start = 1'b1;
        tick(100);
        start = 1'b0;
        drain(80);
        tick(40);

        chk("pc_clk_inv_every_cycle", W'(inv_bad), W'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
